// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int PERIOD_W = 19;

  // One bit lasts prescale*8 clocks; a prescale of 0 behaves like 1.
  function automatic logic [PERIOD_W-1:0] bit_period(input logic [15:0] prescale);
    logic [15:0] p;
    p = (prescale == 16'd0) ? 16'd1 : prescale;
    return {p, 3'b000};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that marks the end of a bit period; tick is high
// while the count sits at zero.
module uart_bit_timer #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_framer.sv
// AXI4-Stream to UART transmitter: one word per frame, start bit, LSB-first
// data, optional parity, one or two stop bits, optional CTS flow control.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit CTS_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  input  logic                  cts_n,
  output logic                  busy,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  uart_state_e state, state_nxt;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_acc;
  logic [PERIOD_W-1:0]   period_q;
  logic [1:0]            par_q;
  logic                  stop2_q;

  logic                  cts_s1, cts_s2, cts_ok;
  logic                  hs, tick, step;
  logic                  timer_load;
  logic [PERIOD_W-1:0]   timer_val;
  logic                  txd_d, busy_d, parity_bit;

  // Valid/ready: a word transfers on a clock edge where s_axis_tvalid and
  // s_axis_tready are both high; tready depends only on state and CTS, never
  // on tvalid, and tdata must stay stable while tvalid waits for tready.
  assign hs   = s_axis_tvalid && s_axis_tready;
  assign step = hs || ((state != IDLE) && tick);

  assign cts_ok = CTS_EN ? !cts_s2 : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= cts_n;
      cts_s2 <= cts_s1;
    end
  end

  // Configuration is captured at the handshake so mid-frame edits only
  // affect the following frame.
  assign timer_load = step && (state_nxt != IDLE);
  assign timer_val  = hs ? (bit_period(prescale) - PERIOD_ONE)
                         : (period_q - PERIOD_ONE);

  uart_bit_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (hs) state_nxt = START;
      START:  if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && (bit_cnt == '0)) begin
          state_nxt = ((par_q == PAR_EVEN) || (par_q == PAR_ODD)) ? PARITY : STOP1;
        end
      end
      PARITY: if (tick) state_nxt = STOP1;
      STOP1:  if (tick) state_nxt = stop2_q ? STOP2 : IDLE;
      STOP2:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign parity_bit = (par_q == PAR_ODD) ? ~par_acc : par_acc;

  // txd and busy are registered: this block picks their values for the bit
  // that starts on the coming edge.
  always_comb begin
    txd_d         = txd;
    busy_d        = busy;
    s_axis_tready = (state == IDLE) && cts_ok;
    if (step) begin
      busy_d = (state_nxt != IDLE);
      case (state_nxt)
        START:   txd_d = 1'b0;
        DATA:    txd_d = shreg[0];
        PARITY:  txd_d = parity_bit;
        default: txd_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd      <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      period_q <= '0;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
    end else begin
      txd  <= txd_d;
      busy <= busy_d;
      if (hs) begin
        shreg    <= s_axis_tdata;
        period_q <= bit_period(prescale);
        par_q    <= parity_mode;
        stop2_q  <= stop2;
        par_acc  <= 1'b0;
      end else if (step && (state_nxt == DATA)) begin
        // Each emitted data bit is folded into the running parity.
        shreg   <= shreg >> 1;
        par_acc <= par_acc ^ shreg[0];
        bit_cnt <= (state == START) ? CNT_LAST : (bit_cnt - CNT_ONE);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: a frame-level model predicts txd,
// busy and tready every cycle; directed frames pin the model with literals.
module tb_uart_tx_framer;

  logic        clk;
  logic        rst;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        txd;
  logic        cts_n;
  logic        busy;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic        stop2;

  int n_vec;
  int n_bad;
  int hs_cnt;

  uart_tx_framer #(.DATA_WIDTH(8), .CTS_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .txd           (txd),
    .cts_n         (cts_n),
    .busy          (busy),
    .prescale      (prescale),
    .parity_mode   (parity_mode),
    .stop2         (stop2)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the txd level for every remaining cycle of accepted frames.
  logic [0:0] exp_q[$];
  logic       cur_txd, cur_busy, exp_tready;
  logic       cts_h1, cts_h2, model_ok;
  bit         model_on;

  task automatic push_frame(input logic [7:0] d, input logic [15:0] ps,
                            input logic [1:0] pm, input logic s2);
    logic bits[$];
    int   p;
    p = ((ps == 16'd0) ? 1 : int'(ps)) * 8;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pm == 2'b01) bits.push_back(^d);
    if (pm == 2'b10) bits.push_back(~^d);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < p; k++) exp_q.push_back(bits[i]);
    end
  endtask

  initial begin
    model_on = 1'b0; cur_txd = 1'b1; cur_busy = 1'b0;
    cts_h1 = 1'b1; cts_h2 = 1'b1; exp_tready = 1'b0;
    n_vec = 0; n_bad = 0; hs_cnt = 0;
  end

  always @(posedge clk) begin
    model_on = 1'b1;
    if (rst) begin
      exp_q.delete();
      cur_txd  = 1'b1;
      cur_busy = 1'b0;
      cts_h1   = 1'b1;
      cts_h2   = 1'b1;
    end else begin
      model_ok = !cts_h2;
      if (!cur_busy && tvalid && model_ok) push_frame(tdata, prescale, parity_mode, stop2);
      cts_h2 = cts_h1;
      cts_h1 = cts_n;
      if (exp_q.size() > 0) begin
        cur_txd  = exp_q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_txd  = 1'b1;
        cur_busy = 1'b0;
      end
    end
    exp_tready = !cur_busy && !cts_h2;
  end

  always @(posedge clk) begin
    if (!rst && tvalid && tready) hs_cnt++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      check("cyc_txd", txd, cur_txd);
      check("cyc_busy", busy, cur_busy);
      check("cyc_tready", tready, exp_tready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [7:0] d, input bit hold);
    int k;
    k = 0;
    @(negedge clk);
    tdata  = d;
    tvalid = 1'b1;
    while (!tready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("send_accept", tready, 1);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      tvalid = 1'b0;
    end
  endtask

  task automatic capture(input int p, input int nb, output logic [15:0] bits, output int blen);
    int c;
    bits = '0;
    blen = 0;
    c = 0;
    while (!busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("capture_start", busy, 1);
    c = 0;
    while (busy && c < 5000) begin
      for (int i = 0; i < nb; i++) if (c == i * p + p / 2) bits[i] = txd;
      blen++;
      c++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || exp_q.size() != 0) && k < 5000);
    check("idle_reached", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] bits_a, bits_b;
  int          len_a, len_b, gap, n0, k;

  logic [7:0]  tab_d [4] = '{8'hFF, 8'h00, 8'h6B, 8'hC4};
  logic [15:0] tab_ps[4] = '{16'd1, 16'd2, 16'd1, 16'd3};
  logic [1:0]  tab_pm[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
  logic        tab_s2[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; tvalid = 1'b0; tdata = '0; cts_n = 1'b0;
    prescale = 16'd1; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_tready", tready, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: 0x55, P=8, no parity, one stop
    fork
      send_word(8'h55, 1'b0);
      capture(8, 10, bits_a, len_a);
    join
    check("t1_bits", bits_a, 16'h02AA);
    check("t1_busy_len", len_a, 80);
    wait_idle();

    // 2: even / odd parity at P=16
    prescale = 16'd2; parity_mode = 2'b01;
    fork
      send_word(8'h07, 1'b0);
      capture(16, 11, bits_a, len_a);
    join
    check("t2_even_bits", bits_a, 16'h060E);
    check("t2_even_len", len_a, 176);
    wait_idle();
    parity_mode = 2'b10;
    fork
      send_word(8'h07, 1'b0);
      capture(16, 11, bits_a, len_a);
    join
    check("t2_odd_bits", bits_a, 16'h040E);
    check("t2_odd_len", len_a, 176);
    wait_idle();

    // 3: two stop bits, back-to-back words with tvalid held
    prescale = 16'd1; parity_mode = 2'b00; stop2 = 1'b1;
    hs_cnt = 0;
    fork
      begin
        send_word(8'hA5, 1'b1);
        send_word(8'h3C, 1'b0);
      end
      begin
        capture(8, 11, bits_a, len_a);
        gap = 0;
        while (!busy && gap < 100) begin
          gap++;
          @(negedge clk);
        end
        capture(8, 11, bits_b, len_b);
      end
    join
    check("t3_bits_a", bits_a, 16'h074A);
    check("t3_len_a", len_a, 88);
    check("t3_gap", gap, 1);
    check("t3_bits_b", bits_b, 16'h0678);
    check("t3_len_b", len_b, 88);
    check("t3_handshakes", hs_cnt, 2);
    wait_idle();

    // 4: CTS flow control
    stop2 = 1'b0;
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    fork
      send_word(8'h96, 1'b0);
      capture(8, 10, bits_a, len_a);
      begin
        n0 = 0;
        repeat (40) begin
          @(negedge clk);
          if (tready || !txd) n0++;
        end
        check("t4_blocked", n0, 0);
        cts_n = 1'b0;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!tready && k < 10);
        check("t4_cts_latency", (k >= 2 && k <= 3), 1);
        repeat (20) @(negedge clk);
        cts_n = 1'b1;
      end
    join
    check("t4_bits", bits_a, 16'h032C);
    check("t4_len", len_a, 80);
    wait_idle();
    check("t4_tready_held", tready, 0);
    cts_n = 1'b0;
    repeat (4) @(negedge clk);

    // 5: reset during data bit 3 aborts the frame
    fork
      send_word(8'hC3, 1'b0);
      begin
        k = 0;
        while (!busy && k < 200) begin
          @(negedge clk);
          k++;
        end
        repeat (34) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_abort_txd", txd, 1);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_tready", tready, 0);
        rst = 1'b0;
      end
    join
    fork
      send_word(8'h3A, 1'b0);
      capture(8, 10, bits_a, len_a);
    join
    check("t5_after_bits", bits_a, 16'h0274);
    check("t5_after_len", len_a, 80);
    wait_idle();

    // 6: prescale 0 and mid-frame configuration changes
    prescale = 16'd0;
    fork
      send_word(8'h81, 1'b0);
      capture(8, 10, bits_a, len_a);
    join
    check("t6_p0_bits", bits_a, 16'h0302);
    check("t6_p0_len", len_a, 80);
    wait_idle();
    prescale = 16'd1;
    fork
      send_word(8'h5A, 1'b0);
      capture(8, 10, bits_a, len_a);
      begin
        repeat (25) @(negedge clk);
        prescale = 16'd3; parity_mode = 2'b10; stop2 = 1'b1;
      end
    join
    check("t6_mid_bits", bits_a, 16'h02B4);
    check("t6_mid_len", len_a, 80);
    wait_idle();
    fork
      send_word(8'h5A, 1'b0);
      capture(24, 12, bits_b, len_b);
    join
    check("t6_new_bits", bits_b, 16'h0EB4);
    check("t6_new_len", len_b, 288);
    wait_idle();

    // Mixed configurations, checked cycle by cycle against the model
    for (int i = 0; i < 4; i++) begin
      prescale = tab_ps[i]; parity_mode = tab_pm[i]; stop2 = tab_s2[i];
      send_word(tab_d[i], 1'b0);
      wait_idle();
    end

    check("end_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
